// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter sharing one common data bus among NUM_FU functional units
// Ports: in_clk/in_rst (async active-high); in_fu_* per-FU result strobe and payload;
//   in_rob_is_mispred flushes all held results; out_fu_ready per-FU slot availability;
//   out_cdb_* registered broadcast with source FU id; out_busy when any slot holds a result.
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 5
`endif

module cdb_arbiter #(
  parameter int NUM_FU = 4
) (
  input  logic                                      in_clk,
  input  logic                                      in_rst,
  input  logic [NUM_FU-1:0]                         in_fu_done,
  input  logic [NUM_FU-1:0][`GPR_SIZE-1:0]          in_fu_value,
  input  logic [NUM_FU-1:0][`ROB_IDX_SIZE-1:0]      in_fu_rob_idx,
  input  logic [NUM_FU-1:0]                         in_fu_set_nzcv,
  input  logic [NUM_FU-1:0][3:0]                    in_fu_nzcv,
  input  logic                                      in_rob_is_mispred,
  output logic [NUM_FU-1:0]                         out_fu_ready,
  output logic                                      out_cdb_valid,
  output logic [`GPR_SIZE-1:0]                      out_cdb_value,
  output logic [`ROB_IDX_SIZE-1:0]                  out_cdb_rob_idx,
  output logic                                      out_cdb_set_nzcv,
  output logic [3:0]                                out_cdb_nzcv,
  output logic [$clog2(NUM_FU)-1:0]                 out_cdb_fu_id,
  output logic                                      out_busy
);
  localparam int IW = $clog2(NUM_FU);
  localparam int JW = IW + 1;
  logic [NUM_FU-1:0]                    r_valid;
  logic [NUM_FU-1:0][`GPR_SIZE-1:0]     r_value;
  logic [NUM_FU-1:0][`ROB_IDX_SIZE-1:0] r_rob_idx;
  logic [NUM_FU-1:0]                    r_set_nzcv;
  logic [NUM_FU-1:0][3:0]               r_nzcv;
  logic [IW-1:0]                        r_rr_ptr;
  logic [NUM_FU-1:0]                    w_grant;
  logic [NUM_FU-1:0]                    w_cap;
  logic                                 w_gnt_any;
  logic [IW-1:0]                        w_gnt_idx;
  logic [JW-1:0]                        w_j;
  // Search upward from the round-robin pointer, wrapping, for the first held result.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_j = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      w_j = {1'b0, r_rr_ptr} + JW'(k);
      w_j = (w_j >= JW'(NUM_FU)) ? w_j - JW'(NUM_FU) : w_j;
      if (!w_gnt_any && r_valid[w_j[IW-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_j[IW-1:0];
      end
    end
    w_grant = w_gnt_any ? (NUM_FU'(1) << w_gnt_idx) : '0;
  end
  // A slot being drained this edge can accept a new result on the same edge.
  assign out_fu_ready = ~r_valid | w_grant;
  assign w_cap = in_fu_done & out_fu_ready;
  assign out_busy = |r_valid;
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_valid <= '0;
      r_value <= '0;
      r_rob_idx <= '0;
      r_set_nzcv <= '0;
      r_nzcv <= '0;
      r_rr_ptr <= '0;
      out_cdb_valid <= 1'b0;
      out_cdb_value <= '0;
      out_cdb_rob_idx <= '0;
      out_cdb_set_nzcv <= 1'b0;
      out_cdb_nzcv <= '0;
      out_cdb_fu_id <= '0;
    end else if (in_rob_is_mispred) begin
      r_valid <= '0;
      out_cdb_valid <= 1'b0;
    end else begin
      r_valid <= (r_valid & ~w_grant) | w_cap;
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_cap[i]) begin
          r_value[i] <= in_fu_value[i];
          r_rob_idx[i] <= in_fu_rob_idx[i];
          r_set_nzcv[i] <= in_fu_set_nzcv[i];
          r_nzcv[i] <= in_fu_nzcv[i];
        end
      end
      out_cdb_valid <= w_gnt_any;
      if (w_gnt_any) begin
        out_cdb_value <= r_value[w_gnt_idx];
        out_cdb_rob_idx <= r_rob_idx[w_gnt_idx];
        out_cdb_set_nzcv <= r_set_nzcv[w_gnt_idx];
        out_cdb_nzcv <= r_nzcv[w_gnt_idx];
        out_cdb_fu_id <= w_gnt_idx;
        r_rr_ptr <= (w_gnt_idx == IW'(NUM_FU - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of the CDB arbiter with hand-computed expectations
module tb_cdb_arbiter;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      done = '0;
  logic [3:0][63:0] value = '0;
  logic [3:0][4:0] rob = '0;
  logic [3:0]      setf = '0;
  logic [3:0][3:0] nzcv = '0;
  logic            mispred = 1'b0;
  logic [3:0]      ready;
  logic            cdb_valid;
  logic [63:0]     cdb_value;
  logic [4:0]      cdb_rob;
  logic            cdb_setf;
  logic [3:0]      cdb_nzcv;
  logic [1:0]      cdb_fu;
  logic            busy;
  int              passed = 0;
  int              total = 0;

  cdb_arbiter #(.NUM_FU(4)) dut (
    .in_clk(clk), .in_rst(rst), .in_fu_done(done), .in_fu_value(value),
    .in_fu_rob_idx(rob), .in_fu_set_nzcv(setf), .in_fu_nzcv(nzcv),
    .in_rob_is_mispred(mispred), .out_fu_ready(ready), .out_cdb_valid(cdb_valid),
    .out_cdb_value(cdb_value), .out_cdb_rob_idx(cdb_rob), .out_cdb_set_nzcv(cdb_setf),
    .out_cdb_nzcv(cdb_nzcv), .out_cdb_fu_id(cdb_fu), .out_busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_ready", 64'(ready), 64'hF);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_valid", 64'(cdb_valid), 0);
    chk("rst_fu", 64'(cdb_fu), 0);
    chk("rst_value", cdb_value, 0);
    tick();
    rst = 1'b0;
    // single FU0 result
    done = 4'b0001; value[0] = 64'h2; rob[0] = 5'd3; setf[0] = 1'b1; nzcv[0] = 4'h0;
    tick();
    done = '0;
    chk("single_busy", 64'(busy), 1);
    chk("single_nobcast_yet", 64'(cdb_valid), 0);
    tick();
    chk("single_valid", 64'(cdb_valid), 1);
    chk("single_value", cdb_value, 64'h2);
    chk("single_rob", 64'(cdb_rob), 3);
    chk("single_fu", 64'(cdb_fu), 0);
    chk("single_setf", 64'(cdb_setf), 1);
    chk("single_nzcv", 64'(cdb_nzcv), 0);
    chk("single_drained", 64'(busy), 0);
    tick();
    chk("single_valid_low", 64'(cdb_valid), 0);
    chk("single_value_hold", cdb_value, 64'h2);
    // FU3 alone moves the round-robin pointer back to 0
    done = 4'b1000; value[3] = 64'h33; rob[3] = 5'd7; setf[3] = 1'b0; nzcv[3] = 4'h9;
    tick();
    done = '0;
    tick();
    chk("fu3_fu", 64'(cdb_fu), 3);
    chk("fu3_value", cdb_value, 64'h33);
    chk("fu3_nzcv", 64'(cdb_nzcv), 4'h9);
    // four-way contention from pointer 0
    done = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      value[i] = 64'h10 + 64'(i); rob[i] = 5'(8 + i);
    end
    tick();
    done = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("cont_valid%0d", i), 64'(cdb_valid), 1);
      chk($sformatf("cont_fu%0d", i), 64'(cdb_fu), 64'(i));
      chk($sformatf("cont_value%0d", i), cdb_value, 64'h10 + 64'(i));
      chk($sformatf("cont_rob%0d", i), 64'(cdb_rob), 64'(8 + i));
    end
    chk("cont_busy_end", 64'(busy), 0);
    // FU0 and FU1 streaming every cycle alternate on the bus
    done = 4'b0011; value[0] = 64'hA0; value[1] = 64'hA1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr_valid%0d", i), 64'(cdb_valid), 1);
      chk($sformatf("rr_fu%0d", i), 64'(cdb_fu), 64'(i % 2));
      chk($sformatf("rr_value%0d", i), cdb_value, (i % 2 == 0) ? 64'hA0 : 64'hA1);
    end
    done = '0;
    tick();
    chk("rr_drain_fu0", 64'(cdb_fu), 0);
    tick();
    chk("rr_drain_fu1", 64'(cdb_fu), 1);
    chk("rr_drain_busy", 64'(busy), 0);
    // pointer is 2; FU3 alone brings it to 0
    done = 4'b1000; value[3] = 64'h3C;
    tick();
    done = '0;
    tick();
    chk("bp_pre_fu", 64'(cdb_fu), 3);
    // backpressure: slot 2 full and waiting behind slot 0
    done = 4'b0101; value[0] = 64'h50; value[2] = 64'h22; rob[2] = 5'd2;
    tick();
    done = 4'b0100; value[2] = 64'hAA;
    #1;
    chk("bp_ready2_low", 64'(ready[2]), 0);
    chk("bp_ready0_high", 64'(ready[0]), 1);
    tick();
    done = '0;
    chk("bp_first_fu", 64'(cdb_fu), 0);
    chk("bp_first_value", cdb_value, 64'h50);
    tick();
    chk("bp_second_fu", 64'(cdb_fu), 2);
    chk("bp_second_value", cdb_value, 64'h22);
    tick();
    chk("bp_no_aa", 64'(cdb_valid), 0);
    chk("bp_busy", 64'(busy), 0);
    // flush with slots 1 and 3 held
    done = 4'b1010; value[1] = 64'h61; value[3] = 64'h63;
    tick();
    done = '0;
    chk("fl_busy_before", 64'(busy), 1);
    mispred = 1'b1;
    tick();
    mispred = 1'b0;
    chk("fl_valid", 64'(cdb_valid), 0);
    chk("fl_busy", 64'(busy), 0);
    chk("fl_value_hold", cdb_value, 64'h22);
    tick();
    chk("fl_no_stale", 64'(cdb_valid), 0);
    tick();
    chk("fl_no_stale2", 64'(cdb_valid), 0);
    // asynchronous reset with a broadcast on the bus and another result held
    done = 4'b0011; value[0] = 64'h70; value[1] = 64'h71;
    tick();
    done = '0;
    tick();
    chk("ar_pre_valid", 64'(cdb_valid), 1);
    chk("ar_pre_busy", 64'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 64'(cdb_valid), 0);
    chk("ar_busy", 64'(busy), 0);
    chk("ar_ready", 64'(ready), 64'hF);
    chk("ar_value", cdb_value, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_nothing1", 64'(cdb_valid), 0);
    tick();
    chk("ar_nothing2", 64'(cdb_valid), 0);
    // after reset the pointer is 0 again
    done = 4'b0110; value[1] = 64'h81; value[2] = 64'h82;
    tick();
    done = '0;
    tick();
    chk("ar_post_fu", 64'(cdb_fu), 1);
    chk("ar_post_value", cdb_value, 64'h81);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 4, number of functional units sharing the common data bus (CDB), legal range 2..8.
REQ-002 SHALL have clock/reset per codebase: in_clk (one clock); in_rst asynchronous, active-high.
REQ-003 in_clk  input  1  clock; all state updates on rising edge.
REQ-004 in_rst  input  1  asynchronous active-high reset.
REQ-005 in_fu_done  input  NUM_FU  per-FU result-valid strobe.
REQ-006 in_fu_value  input  NUM_FU x `GPR_SIZE  per-FU result value.
REQ-007 in_fu_rob_idx  input  NUM_FU x `ROB_IDX_SIZE  per-FU destination ROB index.
REQ-008 in_fu_set_nzcv  input  NUM_FU  per-FU flag-write enable.
REQ-009 in_fu_nzcv  input  NUM_FU x nzcv_t (4)  per-FU flags.
REQ-010 in_rob_is_mispred  input  1  flush request from ROB.
REQ-011 out_fu_ready  output  NUM_FU  per-FU holding slot can accept this cycle.
REQ-012 out_cdb_valid  output  1  broadcast valid to ROB and reservation stations.
REQ-013 out_cdb_value, out_cdb_rob_idx, out_cdb_set_nzcv, out_cdb_nzcv  output  `GPR_SIZE / `ROB_IDX_SIZE / 1 / 4  broadcast payload.
REQ-014 out_cdb_fu_id  output  $clog2(NUM_FU)  index of FU whose result is broadcast.
REQ-015 out_busy  output  1  any holding slot valid.

Function
REQ-016 SHALL hold one slot per FU: valid bit + value, rob_idx, set_nzcv, nzcv.
REQ-017 out_fu_ready[i] SHALL be combinational: ~slot_valid[i] | grant[i]; in_rob_is_mispred has no effect on ready.
REQ-018 Capture: at rising edge with in_fu_done[i] & out_fu_ready[i], slot i SHALL load FU i payload and set valid; in_fu_done[i] while not ready SHALL be ignored (FU must hold and retry).
REQ-019 Grant: combinational one-hot grant to first valid slot at index >= rr_ptr, searching upward with wrap to 0; no grant when no slot valid.
REQ-020 On a granting edge, out_cdb_* SHALL register granted slot payload, out_cdb_valid <= 1, out_cdb_fu_id <= granted index, granted slot valid cleared unless same-edge capture refills it.
REQ-021 rr_ptr SHALL update to (granted index + 1) mod NUM_FU on a granting edge; unchanged otherwise.
REQ-022 Non-granting edge: out_cdb_valid <= 0; payload outputs hold previous values.
REQ-023 Latency: FU done sampled at edge k -> out_cdb_valid high after edge k+1 if uncontended; throughput 1 broadcast/cycle.
REQ-024 Starvation bound: a valid slot SHALL be broadcast within NUM_FU granting edges.
REQ-025 Flush: edge with in_rob_is_mispred=1 SHALL clear all slot valid bits, discard same-edge captures and grant, out_cdb_valid <= 0; rr_ptr unchanged.
REQ-026 out_busy SHALL equal OR of slot valid bits (combinational).
REQ-027 rob_idx and values pass through unmodified; no width conversion.

Reset
REQ-028 in_rst=1 SHALL asynchronously clear all slot valids, rr_ptr=0, out_cdb_valid=0, out_cdb_value=0, out_cdb_rob_idx=0, out_cdb_set_nzcv=0, out_cdb_nzcv=0, out_cdb_fu_id=0; out_fu_ready all 1s, out_busy=0 while reset held.
REQ-029 Reset asserted mid-operation SHALL drop all held results; nothing broadcast until a new capture after reset release.

Verification
REQ-030 Single FU: FU0 done, value=64'h2, rob_idx=3, set_nzcv=1, nzcv=0 at edge k -> out_cdb_valid=1, value=2, rob_idx=3, fu_id=0 after edge k+1; out_cdb_valid=0 after edge k+2.
REQ-031 Contention: FUs 0..3 done same edge k, rr_ptr=0 -> broadcasts fu_id 0,1,2,3 after edges k+1..k+4; out_busy=0 after k+4.
REQ-032 Round-robin fairness: FU0 and FU1 done every cycle continuously -> fu_id alternates 0,1,0,1; neither starves.
REQ-033 Backpressure: FU2 slot full and not granted, in_fu_done[2] with value 64'hAA -> out_fu_ready[2]=0, 64'hAA never broadcast; earlier slot value broadcast unchanged.
REQ-034 Flush: slots 1,3 valid, in_rob_is_mispred=1 for one edge -> out_cdb_valid=0 next cycle, out_busy=0, no stale broadcast thereafter.
REQ-035 Async reset: assert in_rst between edges with slots valid -> out_cdb_valid=0 and out_busy=0 immediately, before next edge.
